// File: rtl/flash_word_fetcher.sv
// flash_word_fetcher: round-robin bus master that fetches 32-bit words from a
// byte-wide flash register slave. Each byte goes through three single
// accesses: address write, status poll loop, data read.
//
// Handshake: a requester raises rN_req_i and holds it until rN_done_o. The
// done pulse lasts exactly one cycle. rN_data_o and rN_err_o are valid with
// that pulse, and rN_data_o holds its value until the port's next done. On
// the bus, m_stb_o and m_cyc_o rise together for one cycle per access.
// m_cyc_o then stays high until the cycle that sees m_ack_i or m_err_i, and
// no new strobe is issued in that cycle.
module flash_word_fetcher #(
  parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
  parameter int          POLL_LIMIT = 255
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic        r0_req_i,
  input  logic [22:0] r0_addr_i,
  output logic        r0_done_o,
  output logic [31:0] r0_data_o,
  output logic        r0_err_o,
  input  logic        r1_req_i,
  input  logic [22:0] r1_addr_i,
  output logic        r1_done_o,
  output logic [31:0] r1_data_o,
  output logic        r1_err_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        busy_o
);

  localparam int CW = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] POLL_LIM = CW'(POLL_LIMIT);

  localparam logic [31:0] ADR_DATA = FLASH_BASE;
  localparam logic [31:0] ADR_ADDR = FLASH_BASE + 32'h4;
  localparam logic [31:0] ADR_STAT = FLASH_BASE + 32'h8;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SET_ADR   = 4'd1,
    WAIT_SET  = 4'd2,
    POLL      = 4'd3,
    WAIT_POLL = 4'd4,
    READ      = 4'd5,
    WAIT_READ = 4'd6,
    DONE      = 4'd7,
    FAIL      = 4'd8
  } state_t;

  state_t          state, state_n;
  logic            gnt;          // granted port: 0 or 1
  logic            rr_last;      // port served most recently
  logic [20:0]     addr_q;       // word address of the granted request
  logic [1:0]      idx;          // byte index within the word
  logic [CW-1:0]   poll_cnt;
  logic [31:0]     asm_q, asm_n;
  logic [31:0]     r0_data_q, r1_data_q;

  logic            grant_load;
  logic            win;
  logic            idx_inc;
  logic            poll_clr;
  logic            poll_inc;
  logic            byte_wr;
  logic            fin_load;
  logic            rr_set;

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_n    = state;
    grant_load = 1'b0;
    win        = gnt;
    idx_inc    = 1'b0;
    poll_clr   = 1'b0;
    poll_inc   = 1'b0;
    byte_wr    = 1'b0;
    rr_set     = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req_i || r1_req_i) begin
          grant_load = 1'b1;
          // When both ask, the port not served last time wins
          if (r0_req_i && r1_req_i) win = ~rr_last;
          else                      win = r1_req_i;
          state_n = SET_ADR;
        end
      end
      SET_ADR: state_n = WAIT_SET;
      WAIT_SET: begin
        if (m_err_i) state_n = FAIL;
        else if (m_ack_i) begin
          poll_clr = 1'b1;
          state_n  = POLL;
        end
      end
      POLL: state_n = WAIT_POLL;
      WAIT_POLL: begin
        if (m_err_i) state_n = FAIL;
        else if (m_ack_i) begin
          if (m_dat_i[0])              state_n = READ;
          else if (poll_cnt == POLL_LIM) state_n = FAIL;
          else begin
            poll_inc = 1'b1;
            state_n  = POLL;
          end
        end
      end
      READ: state_n = WAIT_READ;
      WAIT_READ: begin
        if (m_err_i) state_n = FAIL;
        else if (m_ack_i) begin
          byte_wr = 1'b1;
          if (idx == 2'd3) state_n = DONE;
          else begin
            idx_inc = 1'b1;
            state_n = SET_ADR;
          end
        end
      end
      DONE: begin
        rr_set  = 1'b1;
        state_n = IDLE;
      end
      FAIL: begin
        rr_set  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result registers load on the edge that enters DONE/FAIL, so data is
  // already valid during the done pulse
  assign fin_load = (state != DONE) && (state != FAIL) &&
                    ((state_n == DONE) || (state_n == FAIL));

  // Assembly word: cleared at grant, one byte inserted per data read
  always_comb begin
    asm_n = asm_q;
    if (grant_load)   asm_n = 32'h0;
    else if (byte_wr) asm_n[{idx, 3'b000} +: 8] = m_dat_i[7:0];
  end

  // State register and datapath registers
  always_ff @(posedge clk_bus or posedge rst_bus) begin
    if (rst_bus) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rr_last   <= 1'b1;
      addr_q    <= '0;
      idx       <= 2'd0;
      poll_cnt  <= '0;
      asm_q     <= 32'h0;
      r0_data_q <= 32'h0;
      r1_data_q <= 32'h0;
    end else begin
      state <= state_n;
      asm_q <= asm_n;
      if (grant_load) begin
        gnt    <= win;
        addr_q <= win ? r1_addr_i[22:2] : r0_addr_i[22:2];
        idx    <= 2'd0;
      end else if (idx_inc) begin
        idx <= idx + 2'd1;
      end
      if (poll_clr)      poll_cnt <= '0;
      else if (poll_inc) poll_cnt <= poll_cnt + 1'b1;
      if (rr_set) rr_last <= gnt;
      if (fin_load) begin
        if (gnt) r1_data_q <= asm_n;
        else     r0_data_q <= asm_n;
      end
    end
  end

  // Bus signals decoded from state; address and data held through the wait
  always_comb begin
    m_stb_o = (state == SET_ADR) || (state == POLL) || (state == READ);
    m_cyc_o = m_stb_o || (state == WAIT_SET) || (state == WAIT_POLL) ||
              (state == WAIT_READ);
    m_we_o  = (state == SET_ADR) || (state == WAIT_SET);
    m_dat_o = 32'h0;
    m_adr_o = 32'h0;
    case (state)
      SET_ADR, WAIT_SET: begin
        m_adr_o = ADR_ADDR;
        m_dat_o = {9'b0, addr_q, idx};
      end
      POLL, WAIT_POLL: m_adr_o = ADR_STAT;
      READ, WAIT_READ: m_adr_o = ADR_DATA;
      default: m_adr_o = 32'h0;
    endcase
  end

  assign m_sel_o   = 4'hF;
  assign busy_o    = (state != IDLE);
  assign r0_done_o = ((state == DONE) || (state == FAIL)) && !gnt;
  assign r1_done_o = ((state == DONE) || (state == FAIL)) && gnt;
  assign r0_err_o  = (state == FAIL) && !gnt;
  assign r1_err_o  = (state == FAIL) && gnt;
  assign r0_data_o = r0_data_q;
  assign r1_data_o = r1_data_q;

endmodule

// File: tb/tb_flash_word_fetcher.sv
// Directed bench for flash_word_fetcher with a behavioural flash register slave.
module tb_flash_word_fetcher;

  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic        r0_req_i, r1_req_i;
  logic [22:0] r0_addr_i, r1_addr_i;
  logic        r0_done_o, r1_done_o, r0_err_o, r1_err_o;
  logic [31:0] r0_data_o, r1_data_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i, busy_o;
  logic [3:0]  m_sel_o;

  int vectors     = 0;
  int miscompares = 0;

  // Slave controls
  int          busy_polls  = 0;   // not-ready polls before ready, per byte
  int          err_byte    = -1;  // byte index whose data read gets m_err_i
  int          total_polls = 0;
  logic        chk_bus     = 1'b0;
  logic        watch_b1    = 1'b0;
  logic        seen_b1     = 1'b0;
  logic [64:0] exp_q[$];          // {we, adr, dat}

  flash_word_fetcher dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus),
    .r0_req_i(r0_req_i), .r0_addr_i(r0_addr_i), .r0_done_o(r0_done_o),
    .r0_data_o(r0_data_o), .r0_err_o(r0_err_o),
    .r1_req_i(r1_req_i), .r1_addr_i(r1_addr_i), .r1_done_o(r1_done_o),
    .r1_data_o(r1_data_o), .r1_err_o(r1_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .busy_o(busy_o)
  );

  // Clock
  always #5 clk_bus = ~clk_bus;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [22:0] a);
    case (a)
      23'h000100: return 8'h11;
      23'h000101: return 8'h22;
      23'h000102: return 8'h33;
      23'h000103: return 8'h44;
      23'h000200: return 8'hA1;
      23'h000201: return 8'hB2;
      23'h000202: return 8'hC3;
      23'h000203: return 8'hD4;
      23'h000300: return 8'h55;
      23'h000301: return 8'h66;
      23'h000302: return 8'h77;
      23'h000303: return 8'h88;
      23'h7FFFFC: return 8'h01;
      23'h7FFFFD: return 8'h02;
      23'h7FFFFE: return 8'h03;
      23'h7FFFFF: return 8'h04;
      default:    return 8'hEE;
    endcase
  endfunction

  // Flash register slave: acks the cycle after each strobe
  initial begin
    logic [22:0] fa;
    int          pcnt;
    logic [31:0] rdata;
    logic        is_err;
    logic [64:0] item;
    fa = '0; pcnt = 0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = 32'h0;
    forever begin
      @(negedge clk_bus);
      if (m_stb_o && !rst_bus) begin
        if (chk_bus) begin
          if (exp_q.size() == 0) check("bus_extra_access", m_adr_o, 32'hFFFF_FFFF);
          else begin
            item = exp_q.pop_front();
            check("bus_we", {31'b0, m_we_o}, {31'b0, item[64]});
            check("bus_adr", m_adr_o, item[63:32]);
            check("bus_dat", m_dat_o, item[31:0]);
          end
        end
        rdata  = 32'h0;
        is_err = 1'b0;
        if (m_we_o && m_adr_o == 32'h1000_0004) begin
          fa   = m_dat_o[22:0];
          pcnt = 0;
        end else if (!m_we_o && m_adr_o == 32'h1000_0008) begin
          total_polls++;
          if (watch_b1 && fa[1:0] == 2'd1) seen_b1 = 1'b1;
          rdata = (pcnt >= busy_polls) ? 32'h1 : 32'h0;
          pcnt++;
        end else if (!m_we_o && m_adr_o == 32'h1000_0000) begin
          if (err_byte == int'(fa[1:0])) is_err = 1'b1;
          rdata = {24'h0, flash_byte(fa)};
        end
        @(posedge clk_bus); #1;
        m_ack_i = !is_err; m_err_i = is_err; m_dat_i = rdata;
        @(posedge clk_bus); #1;
        m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = 32'h0;
      end
    end
  end

  task automatic do_reset();
    rst_bus = 1'b1;
    repeat (3) @(posedge clk_bus);
    #1 rst_bus = 1'b0;
  endtask

  // Counts negedges starting with the request's first cycle
  task automatic wait_done(input int port, input int budget, output int cyc, output logic ok);
    cyc = 0; ok = 1'b0;
    while (cyc < budget && !ok) begin
      @(negedge clk_bus);
      cyc++;
      if ((port == 0 && r0_done_o) || (port == 1 && r1_done_o)) ok = 1'b1;
    end
  endtask

  initial begin
    int   cyc;
    logic ok;
    int   dn;
    rst_bus = 1'b1;
    r0_req_i = 1'b0; r1_req_i = 1'b0; r0_addr_i = '0; r1_addr_i = '0;

    // Reset values
    #1;
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_cyc_stb", {30'b0, m_cyc_o, m_stb_o}, 32'h0);
    check("rst_sel", {28'b0, m_sel_o}, 32'hF);
    check("rst_adr", m_adr_o, 32'h0);
    check("rst_done", {30'b0, r0_done_o, r1_done_o}, 32'h0);
    check("rst_data", r0_data_o | r1_data_o, 32'h0);
    repeat (2) @(posedge clk_bus);
    #1 rst_bus = 1'b0;

    // Single fetch with full bus sequence
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({1'b1, 32'h1000_0004, 32'h100 + 32'(k)});
      exp_q.push_back({1'b0, 32'h1000_0008, 32'h0});
      exp_q.push_back({1'b0, 32'h1000_0000, 32'h0});
    end
    chk_bus = 1'b1;
    @(posedge clk_bus); #1;
    r0_addr_i = 23'h000100; r0_req_i = 1'b1;
    wait_done(0, 200, cyc, ok);
    check("single_done_seen", {31'b0, ok}, 32'h1);
    check("single_latency", 32'(cyc), 32'd26);
    check("single_data", r0_data_o, 32'h4433_2211);
    check("single_err", {31'b0, r0_err_o}, 32'h0);
    r0_req_i = 1'b0;
    chk_bus = 1'b0;
    check("single_bus_left", 32'(exp_q.size()), 32'h0);

    // Slow flash: three not-ready polls per byte
    busy_polls = 3;
    @(posedge clk_bus); #1;
    r0_addr_i = 23'h000300; r0_req_i = 1'b1;
    wait_done(0, 300, cyc, ok);
    check("slow_done_seen", {31'b0, ok}, 32'h1);
    check("slow_latency", 32'(cyc), 32'd50);
    check("slow_data", r0_data_o, 32'h8877_6655);
    r0_req_i = 1'b0;

    // Timeout: status never ready
    busy_polls = 100000; total_polls = 0;
    @(posedge clk_bus); #1;
    r1_addr_i = 23'h000200; r1_req_i = 1'b1;
    wait_done(1, 2000, cyc, ok);
    check("tmo_done_seen", {31'b0, ok}, 32'h1);
    check("tmo_err", {31'b0, r1_err_o}, 32'h1);
    check("tmo_data", r1_data_o, 32'h0);
    check("tmo_polls", 32'(total_polls), 32'd256);
    r1_req_i = 1'b0;
    @(negedge clk_bus);
    check("tmo_idle", {31'b0, busy_o}, 32'h0);
    busy_polls = 0;

    // Bus error on the data read of byte 2
    err_byte = 2;
    @(posedge clk_bus); #1;
    r1_addr_i = 23'h000200; r1_req_i = 1'b1;
    wait_done(1, 200, cyc, ok);
    check("berr_done_seen", {31'b0, ok}, 32'h1);
    check("berr_err", {31'b0, r1_err_o}, 32'h1);
    check("berr_data", r1_data_o, 32'h0000_B2A1);
    check("berr_r0_quiet", {31'b0, r0_done_o}, 32'h0);
    r1_req_i = 1'b0;
    err_byte = -1;

    // Wrap-around, low address bits ignored, address change after grant ignored
    @(posedge clk_bus); #1;
    r0_addr_i = 23'h7FFFFE; r0_req_i = 1'b1;
    repeat (3) @(negedge clk_bus);
    r0_addr_i = 23'h000100;
    wait_done(0, 200, cyc, ok);
    check("wrap_done_seen", {31'b0, ok}, 32'h1);
    check("wrap_data", r0_data_o, 32'h0403_0201);
    check("wrap_err", {31'b0, r0_err_o}, 32'h0);
    r0_req_i = 1'b0;

    // Arbitration from reset; r0 re-asserts right after its done
    do_reset();
    r0_addr_i = 23'h000100; r1_addr_i = 23'h000200;
    r0_req_i = 1'b1; r1_req_i = 1'b1;
    wait_done(0, 200, cyc, ok);
    check("arb_r0_first", {31'b0, ok}, 32'h1);
    check("arb_r0_data", r0_data_o, 32'h4433_2211);
    check("arb_r1_waiting", {31'b0, r1_done_o}, 32'h0);
    r0_req_i = 1'b0;
    @(posedge clk_bus); #1;
    r0_req_i = 1'b1;
    wait_done(1, 200, cyc, ok);
    check("arb_r1_second", {31'b0, ok}, 32'h1);
    check("arb_r1_data", r1_data_o, 32'hD4C3_B2A1);
    r1_req_i = 1'b0;
    wait_done(0, 200, cyc, ok);
    check("arb_r0_third", {31'b0, ok}, 32'h1);
    check("arb_r1_held", r1_data_o, 32'hD4C3_B2A1);
    r0_req_i = 1'b0;

    // Reset during WAIT_POLL of byte 1
    seen_b1 = 1'b0; watch_b1 = 1'b1;
    @(posedge clk_bus); #1;
    r0_addr_i = 23'h000300; r0_req_i = 1'b1;
    cyc = 0;
    while (!seen_b1 && cyc < 200) begin
      @(posedge clk_bus);
      cyc++;
    end
    check("midrst_reached", {31'b0, seen_b1}, 32'h1);
    watch_b1 = 1'b0;
    #2 rst_bus = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy_o}, 32'h0);
    check("midrst_cyc_stb", {30'b0, m_cyc_o, m_stb_o}, 32'h0);
    check("midrst_adr", m_adr_o, 32'h0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_bus);
      if (r0_done_o || r1_done_o) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'h0);
    @(posedge clk_bus); #1 rst_bus = 1'b0;
    wait_done(0, 200, cyc, ok);
    check("midrst_restart_seen", {31'b0, ok}, 32'h1);
    check("midrst_restart_latency", 32'(cyc), 32'd26);
    check("midrst_restart_data", r0_data_o, 32'h8877_6655);
    r0_req_i = 1'b0;

    repeat (2) @(posedge clk_bus);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
